// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the pipeline's data-memory port. Accepts one
//   read or write request at a time, holds busy_o while the request is in
//   flight, and completes it after LATENCY cycles with a one-cycle ack_o.
//   Misaligned or out-of-range requests complete after one cycle with
//   err_o=1 and never touch the array.
//
//   state | meaning
//   IDLE  | waiting for req_i; request inputs are sampled here
//   BUSY  | good request in flight, counter running down to the ack
//   RESP  | one-cycle ack; the array access happened on the edge into this state
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   req_i    request valid (sampled only in IDLE)
//   we_i     1 = write, 0 = read
//   addr_i   byte address, must be word aligned and below DEPTH*4
//   wdata_i  write data
//   rdata_o  read data, held until the next ack
//   ack_o    one-cycle completion pulse
//   err_o    error flag, valid with ack_o
//   busy_o   request in flight

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            we_q, bad_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            accept, req_bad, enter_resp;
  logic [AW-1:0]   req_idx;
  logic            acc_we, acc_bad;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;

  assign req_bad = (addr_i[1:0] != 2'b00) || ((addr_i >> 2) >= 32'(DEPTH));
  assign req_idx = addr_i[2 +: AW];
  assign accept  = (state_q == IDLE) && req_i;

  // The edge into RESP may be the accept edge itself (error or single-cycle
  // latency), in which case the live inputs are used instead of the latches.
  always_comb begin
    acc_we    = we_q;
    acc_bad   = bad_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_we    = we_i;
      acc_bad   = req_bad;
      acc_idx   = req_idx;
      acc_wdata = wdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (req_bad || (LATENCY == 1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= CNT_LOAD;
      we_q    <= we_i;
      bad_q   <= req_bad;
      idx_q   <= req_idx;
      wdata_q <= wdata_i;
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Array is deliberately not reset; a reset only suppresses a pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_we && !acc_bad) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (enter_resp) begin
      if (acc_bad)     rdata_o <= '0;
      else if (!acc_we) rdata_o <= mem[acc_idx];
    end
  end

  assign busy_o = (state_q != IDLE);
  assign ack_o  = (state_q == RESP);
  assign err_o  = (state_q == RESP) && bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_w [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_at_edge = 1'b1;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] last_m [2];
  logic [31:0] hold_r [2];
  bit          b2b_mode [2];
  bit          prev_in_mode [2];
  int          last_ack [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .wdata_i(wdata_s[0]), .rdata_o(rdata_w[0]),
    .ack_o(ack_w[0]), .err_o(err_w[0]), .busy_o(busy_w[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .wdata_i(wdata_s[1]), .rdata_o(rdata_w[1]),
    .ack_o(ack_w[1]), .err_o(err_w[1]), .busy_o(busy_w[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push_exp(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t pop_exp(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic exp_t front_exp(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[dut%0d] cycle %0d: got %h required %h", name, k, cyc, act, req);
    end
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor / scoreboard: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst_at_edge) begin
        chk("reset_ack", k, 32'(ack_w[k]), 32'd0);
        chk("reset_busy", k, 32'(busy_w[k]), 32'd0);
        chk("reset_err", k, 32'(err_w[k]), 32'd0);
        chk("reset_rdata", k, rdata_w[k], 32'd0);
        hold_r[k]       = 32'd0;
        prev_in_mode[k] = 1'b0;
      end else begin
        chk("busy", k, 32'(busy_w[k]), 32'(qsize(k) != 0));
        if (ack_w[k]) begin
          if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack[dut%0d] cycle %0d: got ack_o=1 required ack_o=0", k, cyc);
          end else begin
            e = pop_exp(k);
            chk("ack_cycle", k, 32'(cyc), 32'(e.cyc));
            chk("err", k, 32'(err_w[k]), 32'(e.err));
            chk("rdata", k, rdata_w[k], e.rdata);
            hold_r[k] = e.rdata;
            if (b2b_mode[k] && prev_in_mode[k])
              chk("b2b_spacing", k, 32'(cyc - last_ack[k]), 32'(lat_of(k) + 1));
            prev_in_mode[k] = b2b_mode[k];
            last_ack[k]     = cyc;
          end
        end else begin
          chk("err_idle", k, 32'(err_w[k]), 32'd0);
          chk("rdata_hold", k, rdata_w[k], hold_r[k]);
          if (qsize(k) != 0) begin
            e = front_exp(k);
            if (cyc > e.cyc) begin
              checks++;
              errors++;
              $display("FAIL ack_missing[dut%0d] cycle %0d: got no ack required ack at cycle %0d", k, cyc, e.cyc);
              void'(pop_exp(k));
            end
          end
        end
      end
    end
  end

  // Reference behaviour: a good write updates the word and leaves rdata alone,
  // a good read returns the word, a bad request returns 0 with err.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   bad;
    logic [$clog2(DEPTH)-1:0] idx;
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    @(posedge clk);
    bad = (a % 4 != 0) || ((a / 4) >= DEPTH);
    idx = a[2 +: $clog2(DEPTH)];
    e.cyc = cyc + 1 + (bad ? 0 : lat_of(k) - 1);
    e.err = bad;
    if (bad)    e.rdata = 32'd0;
    else if (w) begin mem_m[k][idx] = d; e.rdata = last_m[k]; end
    else        e.rdata = mem_m[k][idx];
    last_m[k] = e.rdata;
    push_exp(k, e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_w[k]) break;
      req_s[k]   = 1'($urandom_range(0, 1));
      we_s[k]    = 1'($urandom_range(0, 1));
      addr_s[k]  = (i == 0) ? a + 32'd4 : $urandom;
      wdata_s[k] = $urandom;
    end
    req_s[k] = 1'b0;
  endtask

  task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = 1'b1; addr_s[k] = a; wdata_s[k] = d;
    @(posedge clk);
    e.cyc = cyc + lat_of(k); e.err = 1'b0; e.rdata = last_m[k];
    push_exp(k, e);
    @(negedge clk);
    req_s[k] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    last_m[0] = 32'd0;
    last_m[1] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic init_mem(input int k);
    for (int i = 0; i < DEPTH; i++) issue(k, 1'b1, 32'(i) << 2, $urandom);
  endtask

  task automatic random_ops(input int k, input int n);
    logic [31:0] a;
    int r;
    for (int j = 0; j < n; j++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
      else             a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(k, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  task automatic b2b_run(input int k, input int pairs);
    logic [31:0] a;
    @(negedge clk);
    b2b_mode[k] = 1'b1;
    for (int j = 0; j < pairs; j++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      issue(k, 1'b1, a, $urandom);
      issue(k, 1'b0, a, 32'd0);
    end
    @(negedge clk);
    b2b_mode[k] = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b1; we_s[k] = 1'b1; addr_s[k] = 32'h10; wdata_s[k] = 32'hDEAD_BEEF;
      last_m[k] = 32'd0; b2b_mode[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;

    init_mem(0);
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h10, 32'd0);
    issue(0, 1'b1, 32'h13, 32'hCAFE_F00D);
    issue(0, 1'b0, 32'h10, 32'd0);
    issue(0, 1'b0, 32'h400, 32'd0);
    issue(0, 1'b1, 32'h20, 32'h1111);
    issue(0, 1'b0, 32'h20, 32'd0);
    issue(0, 1'b0, 32'h24, 32'd0);
    abort_write(0, 32'h30, 32'h5A5A);
    issue(0, 1'b0, 32'h30, 32'd0);
    b2b_run(0, 5);
    random_ops(0, 150);

    init_mem(1);
    b2b_run(1, 40);
    random_ops(1, 150);

    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
